// File: rtl/dif_fft8.sv
// ============================================================================
// dif_fft8 -- pipelined 8-point radix-2 decimation-in-frequency FFT
// ----------------------------------------------------------------------------
// Takes one complete frame of eight complex samples per clock and produces
// the eight frequency bins in natural order three clocks later.  Every
// butterfly halves its results, so the output is the DFT scaled by 1/8 and
// can never overflow.
//
// Sample packing (inputs and outputs): [31:16] real, [15:0] imaginary,
// both signed Q1.15.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   xn0..xn7 carry a frame this cycle
//   xn0..xn7   in   32  time samples x[0]..x[7]
//   out_valid  out  1   xk0..xk7 carry a finished frame
//   xk0..xk7   out  32  frequency bins X[0]..X[7], natural order
//
// Parameter
//   TW         cos(pi/4) in Q1.15, the magnitude used by W8^1 and W8^3
//
// Build option
//   DIF_FFT_ROUND_EN  when defined, every halving and every twiddle rescale
//                     adds half an LSB before shifting (round half up).
//                     When undefined, plain arithmetic-shift truncation.
//                     Latency and interface are the same in both builds.
// ============================================================================
module dif_fft8 #(
    parameter int TW = 23170
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] xn0,
    input  logic [31:0] xn1,
    input  logic [31:0] xn2,
    input  logic [31:0] xn3,
    input  logic [31:0] xn4,
    input  logic [31:0] xn5,
    input  logic [31:0] xn6,
    input  logic [31:0] xn7,
    output logic        out_valid,
    output logic [31:0] xk0,
    output logic [31:0] xk1,
    output logic [31:0] xk2,
    output logic [31:0] xk3,
    output logic [31:0] xk4,
    output logic [31:0] xk5,
    output logic [31:0] xk6,
    output logic [31:0] xk7
);

    // Twiddle magnitude widened so the 18 x 18 product stays signed.
    localparam logic signed [35:0] TWC = 36'(TW);

    // ------------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------------

    // Clamp a wide signed value into the Q1.15 range.
    function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
        if (v > 36'sd32767) begin
            return 16'sh7fff;
        end else if (v < -36'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Halve a 17-bit sum or difference.  With truncation the result always
    // fits 16 bits; with rounding the difference 32767 - (-32768) would
    // round up to 32768, so the clamp keeps that single corner in range.
    function automatic logic signed [15:0] shr1(input logic [16:0] v);
        logic signed [35:0] t;
        t = {{19{v[16]}}, v};
`ifdef DIF_FFT_ROUND_EN
        t = t + 36'sd1;
`endif
        return sat16(t >>> 1);
    endfunction

    // Multiply an 18-bit signed value by cos(pi/4) and rescale by 2^-15.
    // (a+b) can reach 65534, and 65534 * 0.7071 exceeds full scale, so the
    // result is clamped.
    function automatic logic signed [15:0] mulc(input logic [17:0] v);
        logic signed [35:0] p;
        p = $signed({{18{v[17]}}, v}) * TWC;
`ifdef DIF_FFT_ROUND_EN
        p = p + 36'sd16384;
`endif
        return sat16(p >>> 15);
    endfunction

    // Rotate d = a + jb by W8^k, k = 0..3.  Returns {re, im}.
    // W8^2 = -j is an exact swap and negate; only -(-32768) needs a clamp.
    // For W8^3 the negation is taken before the rescale, so truncation of
    // the negative product rounds toward minus infinity like every other
    // shift in the datapath.
    function automatic logic [31:0] twiddle(input logic [1:0] k,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        logic [17:0]        apb;
        logic [17:0]        bma;
        logic signed [15:0] re;
        logic signed [15:0] im;
        apb = {{2{a[15]}}, a} + {{2{b[15]}}, b};
        bma = {{2{b[15]}}, b} - {{2{a[15]}}, a};
        re  = a;
        im  = b;
        case (k)
            2'd1: begin
                re = mulc(apb);
                im = mulc(bma);
            end
            2'd2: begin
                re = b;
                im = sat16(36'sd0 - $signed({{20{a[15]}}, a}));
            end
            2'd3: begin
                re = mulc(bma);
                im = mulc(18'd0 - apb);
            end
            default: begin
                re = a;
                im = b;
            end
        endcase
        return {re, im};
    endfunction

    // Radix-2 DIF butterfly on packed complex words p and q.
    // Returns {sum, rotated difference}, each a packed 32-bit complex word.
    // Sums and differences are formed at 17 bits so they never wrap.
    function automatic logic [63:0] bfly(input logic [31:0] p,
                                         input logic [31:0] q,
                                         input logic [1:0]  k);
        logic [15:0] sr;
        logic [15:0] si;
        logic [15:0] dr;
        logic [15:0] di;
        sr = shr1({p[31], p[31:16]} + {q[31], q[31:16]});
        si = shr1({p[15], p[15:0]}  + {q[15], q[15:0]});
        dr = shr1({p[31], p[31:16]} - {q[31], q[31:16]});
        di = shr1({p[15], p[15:0]}  - {q[15], q[15:0]});
        return {sr, si, twiddle(k, dr, di)};
    endfunction

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic [7:0][31:0] x;
    logic [7:0][31:0] n1;
    logic [7:0][31:0] n2;
    logic [7:0][31:0] n3;
    logic [7:0][31:0] s1;
    logic [7:0][31:0] s2;
    logic [7:0][31:0] s3;
    logic             v1;
    logic             v2;

    assign x = {xn7, xn6, xn5, xn4, xn3, xn2, xn1, xn0};

    // Stage 1 combines samples four apart; the difference of pair n is
    // rotated by W8^n and lands in slot n+4.
    for (genvar j = 0; j < 4; j++) begin : g_st1
        assign {n1[j], n1[j+4]} = bfly(x[j], x[j+4], 2'(j));
    end

    // Stage 2 works inside each half, combining slots two apart.  The
    // second pair of each half (m = 1) takes the -j rotation.
    for (genvar j = 0; j < 4; j++) begin : g_st2
        localparam int         P = (j / 2) * 4 + (j % 2);
        localparam logic [1:0] K = ((j % 2) == 1) ? 2'd2 : 2'd0;
        assign {n2[P], n2[P+2]} = bfly(s1[P], s1[P+2], K);
    end

    // Stage 3 combines neighbouring slots with no rotation.
    for (genvar j = 0; j < 4; j++) begin : g_st3
        assign {n3[2*j], n3[2*j+1]} = bfly(s2[2*j], s2[2*j+1], 2'd0);
    end

    // Stage 1 register: captures the first butterfly column whenever a new
    // frame arrives and holds otherwise.  Reset wipes any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                s1 <= n1;
            end
        end
    end

    // Stage 2 register: advances only when stage 1 holds a live frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                s2 <= n2;
            end
        end
    end

    // Stage 3 register doubles as the output register, so the bins stay
    // stable between frames and out_valid lines up with them exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s3        <= '0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                s3 <= n3;
            end
        end
    end

    // DIF leaves the bins in bit-reversed slot order; untangle by wiring.
    assign xk0 = s3[0];
    assign xk4 = s3[1];
    assign xk2 = s3[2];
    assign xk6 = s3[3];
    assign xk1 = s3[4];
    assign xk5 = s3[5];
    assign xk3 = s3[6];
    assign xk7 = s3[7];

endmodule

// File: tb/tb_dif_fft8.sv
// ============================================================================
// tb_dif_fft8 -- self-checking bench for dif_fft8
// ----------------------------------------------------------------------------
// Drives directed frames (impulse, DC, alternating, saturation corners) and
// random frames, and compares every output cycle against a reference model
// that runs the fixed-point DIF FFT with plain integer arithmetic over a
// generic stride loop, then bit-reverses the result.  A three-entry history
// of applied frames supplies the expected pipeline timing.
// Honours DIF_FFT_ROUND_EN the same way the design does.
// ============================================================================
module tb_dif_fft8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] xn0, xn1, xn2, xn3, xn4, xn5, xn6, xn7;
    logic        out_valid;
    logic [31:0] xk0, xk1, xk2, xk3, xk4, xk5, xk6, xk7;

    logic [7:0][31:0] act_xk;
    assign act_xk = {xk7, xk6, xk5, xk4, xk3, xk2, xk1, xk0};

    int checks = 0;
    int passes = 0;

    // expected-output state: history of the last three applied cycles
    logic [2:0]       hv;
    logic [7:0][31:0] hf [3];
    logic             exp_valid;
    logic [7:0][31:0] exp_xk;

    logic [7:0][31:0] zero_f, imp_f, dc_f, alt_f, satw1_f, satw2_f, fa, fb, fc;
    logic [7:0][31:0] imp_x, dc_x, alt_x;

    always #5 clk = ~clk;

    dif_fft8 dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .xn0      (xn0),
        .xn1      (xn1),
        .xn2      (xn2),
        .xn3      (xn3),
        .xn4      (xn4),
        .xn5      (xn5),
        .xn6      (xn6),
        .xn7      (xn7),
        .out_valid(out_valid),
        .xk0      (xk0),
        .xk1      (xk1),
        .xk2      (xk2),
        .xk3      (xk3),
        .xk4      (xk4),
        .xk5      (xk5),
        .xk6      (xk6),
        .xk7      (xk7)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int halve(input int v);
`ifdef DIF_FFT_ROUND_EN
        return clamp16((v + 1) >>> 1);
`else
        return clamp16(v >>> 1);
`endif
    endfunction

    function automatic int scale_tw(input int v);
        int p;
        p = v * 23170;
`ifdef DIF_FFT_ROUND_EN
        p = p + 16384;
`endif
        return clamp16(p >>> 15);
    endfunction

    function automatic logic [7:0][31:0] ref_fft(input logic [7:0][31:0] xin);
        int re [8];
        int im [8];
        int p, q, e, a, b, sr, si, s;
        logic [7:0][31:0] res;
        for (int i = 0; i < 8; i++) begin
            re[i] = int'($signed(xin[i][31:16]));
            im[i] = int'($signed(xin[i][15:0]));
        end
        for (int span = 4; span >= 1; span = span / 2) begin
            for (int base = 0; base < 8; base += 2 * span) begin
                for (int m = 0; m < span; m++) begin
                    p  = base + m;
                    q  = p + span;
                    e  = m * (4 / span);
                    sr = halve(re[p] + re[q]);
                    si = halve(im[p] + im[q]);
                    a  = halve(re[p] - re[q]);
                    b  = halve(im[p] - im[q]);
                    re[p] = sr;
                    im[p] = si;
                    case (e)
                        0: begin re[q] = a;                im[q] = b;                  end
                        1: begin re[q] = scale_tw(a + b);  im[q] = scale_tw(b - a);    end
                        2: begin re[q] = b;                im[q] = clamp16(-a);        end
                        default: begin re[q] = scale_tw(b - a); im[q] = scale_tw(-(a + b)); end
                    endcase
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            s = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            res[k] = {re[s][15:0], im[s][15:0]};
        end
        return res;
    endfunction

    function automatic logic [15:0] rand_half();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return 16'h7fff;
        if (sel == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    function automatic logic [7:0][31:0] rand_frame();
        logic [7:0][31:0] f;
        for (int k = 0; k < 8; k++) begin
            f[k] = {rand_half(), rand_half()};
        end
        return f;
    endfunction

    // ------------------------------------------------------------------------
    // Checking and stimulus tasks
    // ------------------------------------------------------------------------
    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        for (int k = 0; k < 8; k++) begin
            checkOne($sformatf("%s xk%0d", tag, k), act_xk[k], exp_xk[k]);
        end
    endtask

    task automatic checkConst(input string tag, input logic [7:0][31:0] want);
        for (int k = 0; k < 8; k++) begin
            checkOne($sformatf("%s const xk%0d", tag, k), act_xk[k], want[k]);
        end
    endtask

    // Drive one cycle, let one rising edge pass, and update expectations.
    task automatic applyStimulus(input logic v, input logic [7:0][31:0] f);
        in_valid = v;
        {xn7, xn6, xn5, xn4, xn3, xn2, xn1, xn0} = f;
        @(posedge clk);
        #1;
        hv    = {hv[1:0], v};
        hf[2] = hf[1];
        hf[1] = hf[0];
        hf[0] = f;
        exp_valid = hv[2];
        if (hv[2]) exp_xk = ref_fft(hf[2]);
    endtask

    task automatic clearModel();
        hv        = '0;
        exp_valid = 1'b0;
        exp_xk    = '0;
        for (int i = 0; i < 3; i++) hf[i] = '0;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        zero_f = '0;
        imp_f  = '0;
        imp_f[0] = 32'h4000_0000;
        satw1_f = '0;
        satw1_f[1] = 32'h7fff_7fff;
        satw1_f[5] = 32'h8000_8000;
        satw2_f = '0;
        satw2_f[1] = 32'h8000_0000;
        satw2_f[5] = 32'h8000_0000;
        satw2_f[3] = 32'h7fff_0000;
        satw2_f[7] = 32'h7fff_0000;
        dc_x  = '0;
        dc_x[0] = 32'h4000_0000;
        alt_x = '0;
        alt_x[4] = 32'h2000_0000;
        for (int k = 0; k < 8; k++) begin
            dc_f[k]  = 32'h4000_0000;
            alt_f[k] = (k % 2 == 0) ? 32'h2000_0000 : 32'he000_0000;
            imp_x[k] = 32'h0800_0000;
        end

        rst = 1'b0;
        in_valid = 1'b0;
        {xn7, xn6, xn5, xn4, xn3, xn2, xn1, xn0} = zero_f;
        clearModel();

        // reset asserted while a frame is offered
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        {xn7, xn6, xn5, xn4, xn3, xn2, xn1, xn0} = imp_f;
        #1;
        checkOutput("reset immediate");
        @(posedge clk);
        #1;
        checkOutput("reset held");
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) begin
            applyStimulus(1'b0, zero_f);
            checkOutput("after release");
        end

        // impulse
        applyStimulus(1'b1, imp_f);  checkOutput("impulse c1");
        applyStimulus(1'b0, zero_f); checkOutput("impulse c2");
        applyStimulus(1'b0, zero_f); checkOutput("impulse c3");
        checkConst("impulse", imp_x);
        applyStimulus(1'b0, zero_f); checkOutput("impulse drop");

        // DC and alternating, one frame each
        applyStimulus(1'b1, dc_f);
        applyStimulus(1'b0, zero_f);
        applyStimulus(1'b0, zero_f); checkOutput("dc");
        checkConst("dc", dc_x);
        applyStimulus(1'b1, alt_f);
        applyStimulus(1'b0, zero_f);
        applyStimulus(1'b0, zero_f); checkOutput("alt");
        checkConst("alt", alt_x);

        // back-to-back frames
        applyStimulus(1'b1, imp_f);  checkOutput("b2b c1");
        applyStimulus(1'b1, dc_f);   checkOutput("b2b c2");
        applyStimulus(1'b1, alt_f);  checkOutput("b2b c3");
        checkConst("b2b impulse", imp_x);
        applyStimulus(1'b0, zero_f); checkOutput("b2b c4");
        checkConst("b2b dc", dc_x);
        applyStimulus(1'b0, zero_f); checkOutput("b2b c5");
        checkConst("b2b alt", alt_x);
        applyStimulus(1'b0, zero_f); checkOutput("b2b drop");

        // saturation corners of the W8^1 and -j rotations
        applyStimulus(1'b1, satw1_f); checkOutput("sat c1");
        applyStimulus(1'b1, satw2_f); checkOutput("sat c2");
        applyStimulus(1'b0, zero_f);  checkOutput("sat w1");
        applyStimulus(1'b0, zero_f);  checkOutput("sat w2");
        applyStimulus(1'b0, zero_f);  checkOutput("sat drop");

        // mid-stream reset with two frames in flight
        fa = rand_frame();
        fb = rand_frame();
        fc = rand_frame();
        applyStimulus(1'b1, fa); checkOutput("mid a");
        applyStimulus(1'b1, fb); checkOutput("mid b");
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        clearModel();
        checkOutput("mid reset");
        @(posedge clk);
        #1;
        checkOutput("mid reset held");
        rst = 1'b0;
        applyStimulus(1'b1, fc);     checkOutput("mid c1");
        applyStimulus(1'b0, zero_f); checkOutput("mid c2");
        applyStimulus(1'b0, zero_f); checkOutput("mid c3");
        applyStimulus(1'b0, zero_f); checkOutput("mid drop");

        // random traffic with gaps
        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), rand_frame());
            checkOutput($sformatf("random %0d", i));
        end
        repeat (3) begin
            applyStimulus(1'b0, zero_f);
            checkOutput("flush");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
